// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer driving a single fully-registered DSP slice; result 3 cycles after last accept.
// Backpressure: in_ready only in ACCUM while pairs remain; result held on out_valid until out_ready.
// Optional DSP_MAC_SEQ_OVF_EN adds a sticky overflow/underflow flag returned with each result.
module dsp_mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [29:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [47:0]      out_p,
    output logic [29:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic             dsp_cea2,
    output logic             dsp_ceb2,
    output logic             dsp_cem,
    output logic             dsp_cep,
    output logic             dsp_cectrl,
    output logic             dsp_cealumode,
    output logic             dsp_ceinmode,
    output logic [6:0]       dsp_opmode,
    output logic [3:0]       dsp_alumode,
    output logic [4:0]       dsp_inmode,
    output logic [2:0]       dsp_carryinsel,
    input  logic [47:0]      dsp_p
`ifdef DSP_MAC_SEQ_OVF_EN
    ,
    input  logic             dsp_overflow,
    input  logic             dsp_underflow,
    output logic             out_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [47:0]      out_p_q, out_p_d;
    logic             v1_q, v2_q, first1_q;
    logic             accept;
    logic [LEN_W-1:0] count_inc;

    assign count_inc = count_q + {{(LEN_W-1){1'b0}}, 1'b1};
    assign in_ready  = (state_q == ACCUM) && (count_q != len_q);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign out_p     = out_p_q;

    // Slice controls: operands pass straight through, clock enables follow the pipeline valids.
    // The first element of a job loads P from M alone so a previous result never leaks in.
    assign dsp_a          = in_a;
    assign dsp_b          = in_b;
    assign dsp_cea2       = accept;
    assign dsp_ceb2       = accept;
    assign dsp_cem        = v1_q;
    assign dsp_cep        = v2_q;
    assign dsp_cectrl     = v1_q;
    assign dsp_cealumode  = v1_q;
    assign dsp_ceinmode   = v1_q;
    assign dsp_opmode     = first1_q ? 7'h05 : 7'h25;
    assign dsp_alumode    = 4'b0000;
    assign dsp_inmode     = 5'b00000;
    assign dsp_carryinsel = 3'b000;

    // Next-state, job length/count and result capture.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        out_p_d = out_p_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                    len_d   = len;
                    if (len == '0) begin
                        out_p_d = 48'd0;
                        state_d = OUT;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    count_d = count_inc;
                    if (count_inc == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // P settles one edge after the last stage-2 valid retires.
                if (!v1_q && !v2_q) begin
                    out_p_d = dsp_p;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and result register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
            out_p_q <= 48'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            out_p_q <= out_p_d;
        end
    end

    // Pipeline valids tracking an accepted pair through the M and P stages.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            first1_q <= 1'b0;
        end else begin
            v1_q     <= accept;
            first1_q <= accept && (count_q == '0);
            v2_q     <= v1_q;
        end
    end

`ifdef DSP_MAC_SEQ_OVF_EN
    logic v3_q, ovf_q;

    // Sticky flag: slice detector outputs are meaningful the cycle after each P update.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            v3_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            v3_q <= v2_q;
            if (state_q == IDLE && start) begin
                ovf_q <= 1'b0;
            end else if (v3_q) begin
                ovf_q <= ovf_q | dsp_overflow | dsp_underflow;
            end
        end
    end

    assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP slice model and result/opmode scoreboards.
// Results checked when the output handshake fires; opmode checked on every control-register enable.
// Backpressure exercised via held-low out_ready and in_valid bubbles.
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_a = '0;
    logic [17:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] out_p;
    logic [29:0] dsp_a;
    logic [17:0] dsp_b;
    logic        dsp_cea2, dsp_ceb2, dsp_cem, dsp_cep, dsp_cectrl, dsp_cealumode, dsp_ceinmode;
    logic [6:0]  dsp_opmode;
    logic [3:0]  dsp_alumode;
    logic [4:0]  dsp_inmode;
    logic [2:0]  dsp_carryinsel;
    logic [47:0] dsp_p;
`ifdef DSP_MAC_SEQ_OVF_EN
    logic        dsp_overflow = 1'b0;
    logic        dsp_underflow = 1'b0;
    logic        out_ovf;
`endif

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LEN_W(8)) dut (
        .clk(clk), .RST(RST), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea2(dsp_cea2), .dsp_ceb2(dsp_ceb2),
        .dsp_cem(dsp_cem), .dsp_cep(dsp_cep), .dsp_cectrl(dsp_cectrl),
        .dsp_cealumode(dsp_cealumode), .dsp_ceinmode(dsp_ceinmode),
        .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode), .dsp_inmode(dsp_inmode),
        .dsp_carryinsel(dsp_carryinsel), .dsp_p(dsp_p)
`ifdef DSP_MAC_SEQ_OVF_EN
        , .dsp_overflow(dsp_overflow), .dsp_underflow(dsp_underflow), .out_ovf(out_ovf)
`endif
    );

    // Behavioural slice: A2/B2 -> M (25x18 signed) -> P with OPMODE-selected Z mux.
    logic [29:0] a2 = '0;
    logic [17:0] b2 = '0;
    logic [47:0] m_r = '0;
    logic [47:0] p_r = '0;
    logic [6:0]  opm_r = '0;
    logic [47:0] ax, bx;
    assign ax    = {{23{a2[24]}}, a2[24:0]};
    assign bx    = {{30{b2[17]}}, b2};
    assign dsp_p = p_r;

    always @(posedge clk) begin
        if (dsp_cea2)   a2    <= dsp_a;
        if (dsp_ceb2)   b2    <= dsp_b;
        if (dsp_cem)    m_r   <= ax * bx;
        if (dsp_cectrl) opm_r <= dsp_opmode;
        if (dsp_cep)    p_r   <= ((opm_r[6:4] == 3'b010) ? p_r : 48'd0) + m_r;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int cea_cnt  = 0;
    logic [47:0] rq[$];
    logic [6:0]  opq[$];
    logic [29:0] ja[4];
    logic [17:0] jb[4];

    always @(posedge clk) if (dsp_cea2) cea_cnt <= cea_cnt + 1;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] prod(input logic [29:0] a, input logic [17:0] b);
        logic [47:0] x, y;
        x = {{23{a[24]}}, a[24:0]};
        y = {{30{b[17]}}, b};
        return x * y;
    endfunction

    // Scoreboard consumers: result on handshake, opmode on each control enable.
    always @(negedge clk) begin
        if (!RST && out_valid && out_ready) begin
            if (rq.size() == 0) check("unexpected_result", out_p, 48'hDEAD);
            else check("result", out_p, rq.pop_front());
        end
        if (!RST && dsp_cectrl) begin
            if (opq.size() == 0) check("unexpected_opmode", {41'd0, dsp_opmode}, 48'hDEAD);
            else check("opmode", {41'd0, dsp_opmode}, {41'd0, opq.pop_front()});
        end
    end

    task automatic send_pair(input logic [29:0] a, input logic [17:0] b, input bit bubble);
        int g;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("in_ready_timeout", 48'd0, 48'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (bubble) @(negedge clk);
    endtask

    // Waits for IDLE, queues expectations, issues start and streams n pairs from ja/jb.
    task automatic run_job(input int n, input bit bubbles);
        int g;
        logic [47:0] acc;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy) check("idle_timeout", 48'd1, 48'd0);
        acc = 48'd0;
        for (int i = 0; i < n; i++) begin
            acc = acc + prod(ja[i], jb[i]);
            opq.push_back((i == 0) ? 7'h05 : 7'h25);
        end
        rq.push_back(acc);
        start = 1'b1;
        len = 8'(n);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) send_pair(ja[i], jb[i], bubbles);
    endtask

    task automatic wait_results;
        int g;
        g = 0;
        while (rq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("results_drained", 48'(rq.size()), 48'd0);
    endtask

    initial begin
        int n;
        int c0;
        // Reset state
        #12;
        check("rst_busy", {47'd0, busy}, 48'd0);
        check("rst_out_valid", {47'd0, out_valid}, 48'd0);
        check("rst_out_p", out_p, 48'd0);
        check("rst_in_ready", {47'd0, in_ready}, 48'd0);
        check("rst_ces", {41'd0, dsp_cea2, dsp_ceb2, dsp_cem, dsp_cep, dsp_cectrl, dsp_cealumode, dsp_ceinmode}, 48'd0);
        check("const_ctrl", {36'd0, dsp_alumode, dsp_inmode, dsp_carryinsel}, 48'd0);
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);

        // LEN=4 no bubbles, plus latency from last accept to out_valid
        ja[0] = 30'd1; ja[1] = 30'd2; ja[2] = 30'd3; ja[3] = 30'd4;
        jb[0] = 18'd5; jb[1] = 18'd6; jb[2] = 18'd7; jb[3] = 18'd8;
        run_job(4, 1'b0);
        check("busy_after_accepts", {47'd0, busy}, 48'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_len4", 48'(n), 48'd3);
        wait_results();

        // LEN=3 signed operands with bubbles between pairs
        ja[0] = 30'(-3); ja[1] = 30'd100; ja[2] = 30'(-1);
        jb[0] = 18'd7;   jb[1] = 18'(-2); jb[2] = 18'(-1);
        run_job(3, 1'b1);
        wait_results();

        // Back-to-back jobs with out_ready held low; out_p must hold
        out_ready = 1'b0;
        ja[0] = 30'd2; ja[1] = 30'd3; jb[0] = 18'd4; jb[1] = 18'd5;
        run_job(2, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {47'd0, out_valid}, 48'd1);
            check("hold_p", out_p, 48'd23);
        end
        out_ready = 1'b1;
        ja[0] = 30'd1; ja[1] = 30'd1; jb[0] = 18'd1; jb[1] = 18'd1;
        run_job(2, 1'b0);
        wait_results();

        // Zero-length job: result next cycle, no operand enable
        c0 = cea_cnt;
        run_job(0, 1'b0);
        check("len0_valid", {47'd0, out_valid}, 48'd1);
        check("len0_p", out_p, 48'd0);
        wait_results();
        repeat (3) @(negedge clk);
        check("len0_no_cea2", 48'(cea_cnt - c0), 48'd0);

        // Reset after 2 of 4 pairs
        ja[0] = 30'd9; ja[1] = 30'd9; ja[2] = 30'd9; ja[3] = 30'd9;
        jb[0] = 18'd9; jb[1] = 18'd9; jb[2] = 18'd9; jb[3] = 18'd9;
        rq.push_back(48'd0);
        for (int i = 0; i < 4; i++) opq.push_back((i == 0) ? 7'h05 : 7'h25);
        start = 1'b1;
        len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        send_pair(ja[0], jb[0], 1'b0);
        send_pair(ja[1], jb[1], 1'b0);
        in_valid = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        check("midrst_busy", {47'd0, busy}, 48'd0);
        check("midrst_ces", {43'd0, dsp_cea2, dsp_cem, dsp_cep, dsp_cectrl, in_ready}, 48'd0);
        rq.delete();
        opq.delete();
        in_valid = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        ja[0] = 30'd6; jb[0] = 18'd7;
        run_job(1, 1'b0);
        wait_results();

        // Maximum-magnitude operands
        ja[0] = 30'(-16777216); ja[1] = 30'(-16777216);
        jb[0] = 18'(-131072);   jb[1] = 18'(-131072);
        run_job(2, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("max_p", out_p, 48'h0400_0000_0000);
`ifdef DSP_MAC_SEQ_OVF_EN
        check("max_ovf", {47'd0, out_ovf}, 48'd0);
`endif
        wait_results();
        check("opq_drained", 48'(opq.size()), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
